// File: rtl/fsx_timing_gen_if.sv
// Timing bundle between the FSX timing generator and its consumers:
// run/scale requests in, raster position, syncs and strobes out.
interface fsx_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             enable;
    logic [1:0]       scale_log2;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic [CNT_W-1:0] x_pix;
    logic [CNT_W-1:0] y_pix;
    logic             hsync;
    logic             vsync;
    logic             csync;
    logic             blank;
    logic             line_start;
    logic             frameDrawn;
    logic             running;
    logic [15:0]      frame_count;

    modport master (
        input  enable, scale_log2,
        output h_count, v_count, x_pix, y_pix,
        output hsync, vsync, csync, blank,
        output line_start, frameDrawn, running, frame_count
    );

    modport slave (
        output enable, scale_log2,
        input  h_count, v_count, x_pix, y_pix,
        input  hsync, vsync, csync, blank,
        input  line_start, frameDrawn, running, frame_count
    );
endinterface

// File: rtl/fsx_timing_gen.sv
// Parametrised video timing generator for the FSX pipeline.
// All outputs are registered from the next raster position, so none skew.
module fsx_timing_gen #(
    parameter int CNT_W     = 12,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int SCALE_MAX = 2,
    parameter int PREFETCH  = 8
) (
    input  logic          clkPixel,
    input  logic          reset,
    fsx_timing_gen_if.master tif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] LS_H   = CNT_W'(H_TOTAL - PREFETCH);
    localparam logic [CNT_W-1:0] V_PRE  = CNT_W'(V_ACTIVE - 1);
    localparam logic [1:0]       SC_MAX = 2'(SCALE_MAX);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [1:0]       sc_q, sc_d, sc_in;
    logic [15:0]      fc_q, fc_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             cs_q, cs_d;
    logic             bl_q, bl_d;
    logic             ls_q, ls_d;
    logic             fd_q, fd_d;
    logic             run_d, hs_a, vs_a, act;

    assign sc_in = (tif.scale_log2 > SC_MAX) ? SC_MAX : tif.scale_log2;

    always_ff @(posedge clkPixel or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sc_q    <= '0;
            fc_q    <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            cs_q    <= 1'b0;
            bl_q    <= 1'b1;
            ls_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sc_q    <= sc_d;
            fc_q    <= fc_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            cs_q    <= cs_d;
            bl_q    <= bl_d;
            ls_q    <= ls_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        sc_d    = sc_q;
        unique case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (tif.enable) begin
                    state_d = RUN;
                    sc_d    = sc_in;
                end
            end
            RUN: begin
                if (h_q == H_END) begin
                    h_d = '0;
                    if (v_q == V_END) begin
                        v_d = '0;
                        // Stop requests are honoured only here, at frame end.
                        if (!tif.enable) state_d = IDLE;
                        else             sc_d    = sc_in;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        run_d = (state_d == RUN);
        hs_a  = run_d && (h_d >= HS_ON) && (h_d < HS_OFF);
        vs_a  = run_d && (v_d >= VS_ON) && (v_d < VS_OFF);
        act   = run_d && (h_d < H_ACT) && (v_d < V_ACT);
        hs_d  = hs_a ? HS_POL : ~HS_POL;
        vs_d  = vs_a ? VS_POL : ~VS_POL;
        cs_d  = hs_a ^ vs_a;
        bl_d  = !act;
        x_d   = act ? (h_d >> sc_d) : '0;
        y_d   = act ? (v_d >> sc_d) : '0;
        ls_d  = run_d && (h_d == LS_H) &&
                ((v_d < V_PRE) || (v_d == V_END));
        fd_d  = run_d && (h_d == '0) && (v_d == V_ACT);
        fc_d  = fd_d ? fc_q + 16'd1 : fc_q;
    end

    assign tif.h_count     = h_q;
    assign tif.v_count     = v_q;
    assign tif.x_pix       = x_q;
    assign tif.y_pix       = y_q;
    assign tif.hsync       = hs_q;
    assign tif.vsync       = vs_q;
    assign tif.csync       = cs_q;
    assign tif.blank       = bl_q;
    assign tif.line_start  = ls_q;
    assign tif.frameDrawn  = fd_q;
    assign tif.running     = (state_q == RUN);
    assign tif.frame_count = fc_q;
endmodule

// File: tb/tb_fsx_timing_gen.sv
// Bench for fsx_timing_gen: small-raster instance checked cycle by cycle,
// plus a default 640x480 instance checked over its first lines.
module tb_fsx_timing_gen;
    typedef struct packed {
        logic [11:0] h, v, x, y;
        logic        hs, vs, cs, bl, ls, fd, run;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];
    logic [26:0] dexp_q[$];

    fsx_timing_gen_if tif ();
    fsx_timing_gen_if tif2 ();

    fsx_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PREFETCH(3)
    ) u_dut (
        .clkPixel(clk),
        .reset   (reset),
        .tif     (tif.master)
    );

    fsx_timing_gen u_def (
        .clkPixel(clk),
        .reset   (reset),
        .tif     (tif2.master)
    );

    always #5 clk = ~clk;

    function automatic obs_t smp();
        return {tif.h_count, tif.v_count, tif.x_pix, tif.y_pix,
                tif.hsync, tif.vsync, tif.csync, tif.blank,
                tif.line_start, tif.frameDrawn, tif.running,
                tif.frame_count};
    endfunction

    // Expected outputs t cycles after the run started (14x7 raster).
    function automatic obs_t mdl(int t, int sc0, int sc1, int fc0);
        obs_t o;
        int h, v, f, sc;
        logic hsa, vsa;
        h = t % 14;
        v = (t / 14) % 7;
        f = t / 98;
        sc = (f == 0) ? sc0 : sc1;
        hsa = (h == 10) || (h == 11);
        vsa = (v == 5);
        o.h = 12'(h);
        o.v = 12'(v);
        o.bl = !((h < 8) && (v < 4));
        o.x = o.bl ? 12'd0 : 12'(h >> sc);
        o.y = o.bl ? 12'd0 : 12'(v >> sc);
        o.hs = !hsa;
        o.vs = !vsa;
        o.cs = hsa ^ vsa;
        o.ls = (h == 11) && ((v < 3) || (v == 6));
        o.fd = (h == 0) && (v == 4);
        o.run = 1'b1;
        o.fc = 16'(fc0 + f + (((t % 98) >= 56) ? 1 : 0));
        return o;
    endfunction

    function automatic obs_t idle(int fc);
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        o.bl = 1'b1;
        o.fc = 16'(fc);
        return o;
    endfunction

    task automatic test_reset();
        obs_t e;
        tif.enable = 1'b0;
        tif.scale_log2 = 2'd0;
        tif2.enable = 1'b0;
        tif2.scale_log2 = 2'd0;
        #3 reset = 1'b0;
        #1;
        e = idle(0);
        total++;
        if (smp() !== e) begin
            bad++;
            $display("FAIL reset_async got=%p exp=%p", smp(), e);
        end
        tif.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (smp() !== e) begin
            bad++;
            $display("FAIL reset_hold got=%p exp=%p", smp(), e);
        end
        tif.enable = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(idle(0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (smp() !== e) begin
                bad++;
                $display("FAIL idle i=%0d got=%p exp=%p", i, smp(), e);
            end
        end
    endtask

    task automatic test_frame();
        obs_t e;
        tif.scale_log2 = 2'd0;
        tif.enable = 1'b1;
        for (int t = 0; t <= 227; t++) begin
            exp_q.push_back(mdl(t, 0, 0, 0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (smp() !== e) begin
                bad++;
                $display("FAIL frame t=%0d got=%p exp=%p", t, smp(), e);
            end
        end
    endtask

    task automatic test_stop();
        obs_t e;
        tif.enable = 1'b0;
        for (int t = 228; t <= 293; t++) begin
            exp_q.push_back(mdl(t, 0, 0, 0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (smp() !== e) begin
                bad++;
                $display("FAIL stop t=%0d got=%p exp=%p", t, smp(), e);
            end
        end
        for (int i = 0; i < 120; i++) begin
            exp_q.push_back(idle(3));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (smp() !== e) begin
                bad++;
                $display("FAIL stop_idle i=%0d got=%p exp=%p", i, smp(), e);
            end
        end
    endtask

    task automatic test_scale();
        obs_t e;
        tif.scale_log2 = 2'd1;
        tif.enable = 1'b1;
        for (int t = 0; t <= 216; t++) begin
            exp_q.push_back(mdl(t, 1, 2, 3));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (smp() !== e) begin
                bad++;
                $display("FAIL scale t=%0d got=%p exp=%p", t, smp(), e);
            end
            if (t == 30) tif.scale_log2 = 2'd3;
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        #2 reset = 1'b0;
        #1;
        e = idle(0);
        total++;
        if (smp() !== e) begin
            bad++;
            $display("FAIL async_reset got=%p exp=%p", smp(), e);
        end
        @(posedge clk);
        #1;
        total++;
        if (smp() !== e) begin
            bad++;
            $display("FAIL reset_held got=%p exp=%p", smp(), e);
        end
        reset = 1'b1;
        for (int t = 0; t < 98; t++) begin
            exp_q.push_back(mdl(t, 2, 2, 0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (smp() !== e) begin
                bad++;
                $display("FAIL restart t=%0d got=%p exp=%p", t, smp(), e);
            end
        end
    endtask

    task automatic test_default();
        logic [26:0] e, got;
        int h, v;
        tif2.enable = 1'b1;
        for (int t = 0; t < 1700; t++) begin
            h = t % 800;
            v = t / 800;
            dexp_q.push_back({12'(h), 12'(v),
                              !((h >= 656) && (h < 752)),
                              1'b1, !(h < 640)});
            @(posedge clk);
            #1;
            e = dexp_q.pop_front();
            got = {tif2.h_count, tif2.v_count,
                   tif2.hsync, tif2.vsync, tif2.blank};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL default t=%0d got=%h exp=%h", t, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stop();
        test_scale();
        test_async_reset();
        test_default();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
